// File: rtl/pkt_channel_arb.sv
// Packet-aware round-robin arbiter: one requester at a time owns the shared
// channel from head to tail, with an idle timeout that forces release.
module pkt_channel_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_head,
  input  logic [NREQ-1:0]    req_tail,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  output logic               out_head,
  output logic               out_tail,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready,
  output logic [NREQ-1:0]    grant,
  output logic               err_proto,
  output logic               err_timeout,
  output logic [7:0]         pkt_count
);

  // state         | meaning
  // ARB_IDLE      | no owner; arbitrate among requesters presenting a head
  // ARB_WAIT_HEAD | owner granted, head beat not yet accepted
  // ARB_BODY      | head accepted, waiting for the tail beat
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_WAIT_HEAD = 2'd1,
    ARB_BODY      = 2'd2
  } arb_state_e;

  localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]  TO_LOAD = 8'(TIMEOUT);
  localparam logic [PW:0] NREQ_W  = (PW+1)'(NREQ);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      idle_cnt_q, idle_cnt_d;
  logic            err_proto_q, err_proto_d;
  logic            err_timeout_q, err_timeout_d;
  logic [7:0]      pkt_count_q, pkt_count_d;

  logic [PW-1:0]   owner_idx;
  logic [PW-1:0]   next_ptr;
  logic            own_valid;
  logic            own_head;
  logic            own_tail;
  logic [DW-1:0]   own_data;
  logic            xfer;
  logic            arb_hit;
  logic [PW-1:0]   arb_idx;
  logic [PW:0]     scan_idx;
  logic            finish;
  logic            expire;

  always_comb begin
    owner_idx = '0;
    own_valid = 1'b0;
    own_head  = 1'b0;
    own_tail  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = PW'(i);
        own_valid = req_valid[i];
        own_head  = req_head[i];
        own_tail  = req_tail[i];
        own_data  = req_data[i*DW +: DW];
      end
    end
  end

  assign next_ptr  = (owner_idx == PW'(NREQ-1)) ? '0 : owner_idx + PW'(1);
  assign xfer      = own_valid & out_ready;
  assign req_ready = grant_q & {NREQ{out_ready}};

  // A non-head beat arriving before the head is swallowed, not forwarded.
  assign out_valid = own_valid & ~((state_q == ARB_WAIT_HEAD) & ~own_head);
  assign out_head  = own_head;
  assign out_tail  = own_tail;
  assign out_data  = own_data;

  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
      if (!arb_hit && req_valid[scan_idx[PW-1:0]] && req_head[scan_idx[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = scan_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    idle_cnt_d    = idle_cnt_q;
    err_proto_d   = err_proto_q;
    err_timeout_d = 1'b0;
    pkt_count_d   = pkt_count_q;
    finish        = 1'b0;
    expire        = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (arb_hit) begin
          grant_d    = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
          state_d    = ARB_WAIT_HEAD;
          idle_cnt_d = TO_LOAD;
        end
      end
      ARB_WAIT_HEAD, ARB_BODY: begin
        if (xfer) begin
          idle_cnt_d = TO_LOAD;
          if (state_q == ARB_WAIT_HEAD) begin
            if (!own_head)     err_proto_d = 1'b1;
            else if (own_tail) finish      = 1'b1;
            else               state_d     = ARB_BODY;
          end else begin
            if (own_tail)      finish      = 1'b1;
            else if (own_head) err_proto_d = 1'b1;
          end
        end else if (idle_cnt_q <= 8'd1) begin
          expire = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q - 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Tail and timeout are exclusive: a tail is a transfer, a timeout needs none.
    if (finish || expire) begin
      state_d  = ARB_IDLE;
      grant_d  = '0;
      rr_ptr_d = next_ptr;
      if (finish) pkt_count_d   = pkt_count_q + 8'd1;
      if (expire) err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      idle_cnt_q    <= '0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      pkt_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  assign grant       = grant_q;
  assign err_proto   = err_proto_q;
  assign err_timeout = err_timeout_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_pkt_channel_arb.sv
// Directed bench for pkt_channel_arb with defaults NREQ=4, DW=8, TIMEOUT=16.
module tb_pkt_channel_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_head;
  logic [3:0]  req_tail;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_head;
  logic        out_tail;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [3:0]  grant;
  logic        err_proto;
  logic        err_timeout;
  logic [7:0]  pkt_count;

  int checks;
  int errors;

  pkt_channel_arb #(.NREQ(4), .DW(8), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_head    (req_head),
    .req_tail    (req_tail),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_head    (out_head),
    .out_tail    (out_tail),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .grant       (grant),
    .err_proto   (err_proto),
    .err_timeout (err_timeout),
    .pkt_count   (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic v, input logic h, input logic t, input logic [7:0] d);
    req_valid[r]       = v;
    req_head[r]        = h;
    req_tail[r]        = t;
    req_data[r*8 +: 8] = d;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_head  = '0;
    req_tail  = '0;
    req_data  = '0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clear_all();
    tick();
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    checks++; if ({err_proto, err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {err_proto, err_timeout}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_alternate();
    int beat [4];
    int pkt [4];
    int npk;
    int ebeat;
    int eo;
    logic [7:0] exp_d;
    logic [3:0] acc;
    logic [3:0] exp_g;
    for (int r = 0; r < 4; r++) begin beat[r] = 0; pkt[r] = 0; end
    npk = 0;
    ebeat = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 24 && npk < 4; cyc++) begin
      for (int r = 0; r < 4; r += 2)
        drive(r, 1'b1, beat[r] == 0, beat[r] == 2, 8'((r << 6) | (pkt[r] << 2) | beat[r]));
      #1;
      if (out_valid && out_ready) begin
        eo    = (npk % 2 == 0) ? 0 : 2;
        exp_d = 8'((eo << 6) | ((npk / 2) << 2) | ebeat);
        checks++;
        if (out_data !== exp_d || out_head !== (ebeat == 0) || out_tail !== (ebeat == 2)) begin
          errors++;
          $display("FAIL alt_beat p%0d b%0d: got data %h head %b tail %b expected data %h head %b tail %b",
                   npk, ebeat, out_data, out_head, out_tail, exp_d, ebeat == 0, ebeat == 2);
        end
        if (ebeat == 0) begin
          exp_g = 4'b0001 << eo;
          checks++; if (grant !== exp_g) begin errors++; $display("FAIL alt_grant p%0d: got %b expected %b", npk, grant, exp_g); end
        end
        ebeat++;
        if (ebeat == 3) begin ebeat = 0; npk++; end
      end
      acc = req_ready & req_valid;
      tick();
      for (int r = 0; r < 4; r += 2) begin
        if (acc[r]) begin
          beat[r]++;
          if (beat[r] == 3) begin beat[r] = 0; pkt[r]++; end
        end
      end
    end
    checks++; if (npk != 4) begin errors++; $display("FAIL alt_packets: got %0d expected 4 within cycle budget", npk); end
    clear_all();
    #1;
    checks++; if (pkt_count !== 8'd4) begin errors++; $display("FAIL alt_pkt_count: got %0d expected 4", pkt_count); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL alt_grant_end: got %b expected 0000", grant); end
  endtask

  task automatic test_single_packet();
    clear_all();
    drive(0, 1'b1, 1'b1, 1'b0, 8'hA0);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_latency: got %b expected 0000", grant); end
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", grant); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    checks++; if ({out_valid, out_head, out_data} !== {2'b11, 8'hA0}) begin errors++; $display("FAIL single_head: got v%b h%b %h expected v1 h1 a0", out_valid, out_head, out_data); end
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 8'hA1);
    #1;
    checks++; if ({out_valid, out_head, out_data} !== {2'b10, 8'hA1}) begin errors++; $display("FAIL single_body1: got v%b h%b %h expected v1 h0 a1", out_valid, out_head, out_data); end
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 8'hA2);
    #1;
    checks++; if ({out_valid, out_data} !== {1'b1, 8'hA2}) begin errors++; $display("FAIL single_body2: got v%b %h expected v1 a2", out_valid, out_data); end
    tick();
    drive(0, 1'b1, 1'b0, 1'b1, 8'hA3);
    #1;
    checks++; if ({out_valid, out_tail, out_data} !== {2'b11, 8'hA3}) begin errors++; $display("FAIL single_tail: got v%b t%b %h expected v1 t1 a3", out_valid, out_tail, out_data); end
    tick();
    clear_all();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected 0000", grant); end
    checks++; if (pkt_count !== 8'd5) begin errors++; $display("FAIL single_pkt_count: got %0d expected 5", pkt_count); end
    checks++; if (err_proto !== 1'b0) begin errors++; $display("FAIL single_err_proto: got %b expected 0", err_proto); end
  endtask

  task automatic test_single_beat();
    clear_all();
    drive(1, 1'b1, 1'b1, 1'b1, 8'h5B);
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL sbeat_grant: got %b expected 0010", grant); end
    checks++; if ({out_valid, out_head, out_tail, out_data} !== {3'b111, 8'h5B}) begin errors++; $display("FAIL sbeat_beat: got v%b h%b t%b %h expected 1 1 1 5b", out_valid, out_head, out_tail, out_data); end
    tick();
    clear_all();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL sbeat_release: got %b expected 0000", grant); end
    checks++; if (pkt_count !== 8'd6) begin errors++; $display("FAIL sbeat_pkt_count: got %0d expected 6", pkt_count); end
  endtask

  task automatic test_timeout();
    clear_all();
    drive(2, 1'b1, 1'b1, 1'b0, 8'h80);
    drive(3, 1'b1, 1'b1, 1'b1, 8'hC3);
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_grant: got %b expected 0100", grant); end
    tick();
    drive(2, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if ({grant, err_timeout} !== {4'b0100, 1'b0}) begin
        errors++;
        $display("FAIL to_hold idle%0d: got grant %b pulse %b expected 0100 0", i, grant, err_timeout);
      end
    end
    tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", err_timeout); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_release: got %b expected 0000", grant); end
    checks++; if (pkt_count !== 8'd6) begin errors++; $display("FAIL to_pkt_count: got %0d expected 6", pkt_count); end
    tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got %b expected 0", err_timeout); end
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL to_next_grant: got %b expected 1000", grant); end
    checks++; if ({out_valid, out_data} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL to_next_beat: got v%b %h expected v1 c3", out_valid, out_data); end
    tick();
    clear_all();
    #1;
    checks++; if (pkt_count !== 8'd7) begin errors++; $display("FAIL to_next_done: got %0d expected 7", pkt_count); end
  endtask

  task automatic test_proto();
    clear_all();
    drive(0, 1'b1, 1'b0, 1'b0, 8'h11);
    tick();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL proto_nohead_win: got %b expected 0000", grant); end
    drive(0, 1'b1, 1'b1, 1'b0, 8'h12);
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL proto_grant: got %b expected 0001", grant); end
    drive(0, 1'b1, 1'b0, 1'b0, 8'h22);
    #1;
    checks++; if ({out_valid, req_ready} !== {1'b0, 4'b0001}) begin errors++; $display("FAIL proto_swallow: got v%b rdy %b expected v0 rdy 0001", out_valid, req_ready); end
    tick();
    checks++; if ({err_proto, grant} !== {1'b1, 4'b0001}) begin errors++; $display("FAIL proto_flag: got err %b grant %b expected 1 0001", err_proto, grant); end
    drive(0, 1'b1, 1'b1, 1'b1, 8'h33);
    #1;
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h33}) begin errors++; $display("FAIL proto_recover: got v%b %h expected v1 33", out_valid, out_data); end
    tick();
    clear_all();
    #1;
    checks++; if ({pkt_count, grant, err_proto} !== {8'd8, 4'b0000, 1'b1}) begin errors++; $display("FAIL proto_sticky: got cnt %0d grant %b err %b expected 8 0000 1", pkt_count, grant, err_proto); end
  endtask

  task automatic test_reset_mid();
    clear_all();
    drive(1, 1'b1, 1'b1, 1'b0, 8'h40);
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rmid_grant: got %b expected 0010", grant); end
    tick();
    drive(1, 1'b1, 1'b0, 1'b0, 8'h41);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_body: got %b expected 1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if ({req_ready, out_valid} !== 5'b00000) begin errors++; $display("FAIL rmid_outputs: got rdy %b v%b expected 0000 0", req_ready, out_valid); end
    checks++; if ({grant, pkt_count, err_proto} !== {4'b0000, 8'd0, 1'b0}) begin errors++; $display("FAIL rmid_state: got grant %b cnt %0d err %b expected 0000 0 0", grant, pkt_count, err_proto); end
    tick();
    tick();
    clear_all();
    drive(0, 1'b1, 1'b1, 1'b0, 8'h50);
    drive(3, 1'b1, 1'b1, 1'b0, 8'h53);
    reset_n = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rmid_idle: got %b expected 0000", grant); end
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant: got %b expected 0001", grant); end
    clear_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alternate();
    test_single_packet();
    test_single_beat();
    test_timeout();
    test_proto();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
